opb_master_single: RTL and testbench

Single-beat OPB bus master that turns a simple valid/ready command interface into one OPB read or write transaction, and returns a one-cycle response with read data and status. It sits opposite OPB slave registers such as `opb_register_ppc2simulink` and `opb_register_simulink2ppc`. Testbench and fabric logic use it to read and write those registers without the PowerPC, including write-then-readback checks. It handles arbitration, slave retry, error acknowledge and a local timeout watchdog.

---
 rtl/opb_master_single.sv | 160 ++++++++++++++++
 tb/tb_opb_master_single.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_master_single.sv
// Single-beat OPB master: one valid/ready command becomes one OPB read or
// write, with arbitration, slave retry, error acknowledge and a watchdog,
// and comes back as a one-cycle response strobe.
module opb_master_single #(
  parameter int C_OPB_AWIDTH     = 32,
  parameter int C_OPB_DWIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 16,
  parameter int C_MAX_RETRY      = 3
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
  input  logic [0:C_OPB_DWIDTH-1]     cmd_wdata,
  input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
  output logic                        rsp_valid,
  output logic [0:C_OPB_DWIDTH-1]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  output logic                        M_request,
  output logic                        M_busLock,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic                        M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  input  logic                        OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_toutSup
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    BACKOFF = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_TOUT = 2'b10;
  localparam logic [1:0] ST_EXH  = 2'b11;

  // The watchdog aborts once it has run past the limit, so the XFER cycle in
  // which the count equals C_TIMEOUT_CYCLES still lets the slave answer.
  localparam logic [8:0] TO_LIMIT  = 9'(C_TIMEOUT_CYCLES + 1);
  localparam logic [3:0] RETRY_MAX = 4'(C_MAX_RETRY);

  state_t                      state_q, state_d;
  logic [1:0]                  status_d;
  logic [0:C_OPB_DWIDTH-1]     rdata_d;
  logic                        retry_inc;
  logic [3:0]                  retry_q;
  logic [8:0]                  wdog_q;
  logic                        rdy_q;

  // Captured command, held from acceptance until the response
  logic                        rnw_q;
  logic [0:C_OPB_AWIDTH-1]     addr_q;
  logic [0:C_OPB_DWIDTH-1]     wdata_q;
  logic [0:C_OPB_DWIDTH/8-1]   be_q;

  assign M_busLock = 1'b0;
  assign M_seqAddr = 1'b0;
  // rdy_q comes out of reset high; masking with reset keeps it low during reset
  // and high on the first cycle afterwards.
  assign cmd_ready = rdy_q & ~OPB_Rst;

  // Next-state and response resolution; slave responses resolved in priority order
  always_comb begin
    state_d   = state_q;
    status_d  = ST_OK;
    rdata_d   = '0;
    retry_inc = 1'b0;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = REQ;
      REQ:     if (OPB_MGrant) state_d = XFER;
      XFER: begin
        if (OPB_errAck) begin
          status_d = ST_ERR;
          state_d  = RESP;
        end else if (OPB_xferAck) begin
          status_d = ST_OK;
          rdata_d  = rnw_q ? OPB_DBus : '0;
          state_d  = RESP;
        end else if (OPB_retry) begin
          if (retry_q == RETRY_MAX) begin
            status_d = ST_EXH;
            state_d  = RESP;
          end else begin
            retry_inc = 1'b1;
            state_d   = BACKOFF;
          end
        end else if (wdog_q == TO_LIMIT) begin
          status_d = ST_TOUT;
          state_d  = RESP;
        end
      end
      BACKOFF: state_d = REQ;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, command capture, counters and registered outputs decoded from next state
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b1;
      retry_q    <= '0;
      wdog_q     <= '0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      M_request  <= 1'b0;
      M_select   <= 1'b0;
      M_RNW      <= 1'b0;
      M_ABus     <= '0;
      M_BE       <= '0;
      M_DBus     <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_rdata  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        be_q    <= cmd_be;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 4'd1;
      end
      // Cleared outside XFER, so every XFER entry starts from zero
      if (state_q != XFER)   wdog_q <= '0;
      else if (!OPB_toutSup) wdog_q <= wdog_q + 9'd1;

      rdy_q      <= (state_d == IDLE);
      M_request  <= (state_d == REQ);
      M_select   <= (state_d == XFER);
      // Bus fields are zero whenever select is low (OR-bus)
      M_RNW      <= (state_d == XFER) & rnw_q;
      M_ABus     <= (state_d == XFER) ? addr_q : '0;
      M_BE       <= (state_d == XFER) ? be_q : '0;
      M_DBus     <= (state_d == XFER && !rnw_q) ? wdata_q : '0;
      rsp_valid  <= (state_d == RESP);
      rsp_status <= (state_d == RESP) ? status_d : ST_OK;
      rsp_rdata  <= (state_d == RESP) ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_opb_master_single.sv
// Self-checking bench for opb_master_single: random arbiter/slave timing plans
// checked against a cycle-budget and register-file model of the command.
module tb_opb_master_single;
  localparam int T    = 16;
  localparam int MAXR = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_ERRX = 2, K_RTY = 3, K_NONE = 4;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [0:31] cmd_addr, cmd_wdata;
  logic [0:3]  cmd_be;
  logic        rsp_valid;
  logic [0:31] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;
  logic [0:31] OPB_DBus;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_master_single dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
    .M_RNW(M_RNW), .M_seqAddr(M_seqAddr), .M_ABus(M_ABus), .M_BE(M_BE),
    .M_DBus(M_DBus), .OPB_MGrant(OPB_MGrant), .OPB_DBus(OPB_DBus),
    .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [logic [31:0]];

  // Current arbiter/slave plan: per attempt grant delay, response delay, kind
  int p_n;
  int p_gd [8];
  int p_d  [8];
  int p_kind [8];
  bit p_sup;

  // Results of the most recent command
  int          last_lat, first_sel, last_sel;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [0:3] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[31-8*i -: 8] = wd[31-8*i -: 8];
    return r;
  endfunction

  // nret retries before the final response of kind fin after dfin cycles
  task automatic mk_plan(input int nret, input int fin, input bit sup, input int dfin);
    p_sup = sup;
    p_n   = (nret > MAXR) ? MAXR + 1 : nret + 1;
    for (int a = 0; a < 8; a++) begin
      p_gd[a]   = $urandom_range(0, 3);
      p_d[a]    = $urandom_range(0, 3);
      p_kind[a] = K_RTY;
    end
    if (nret <= MAXR) begin
      p_kind[nret] = fin;
      p_d[nret]    = dfin;
    end
  endtask

  // Issue one command at a negedge with cmd_ready high, play arbiter and slave,
  // and check latency, status, read data and bus contents against the model.
  task automatic run_cmd(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [0:3] be);
    int lat, sel_exp, st, dur, k, att, rc, xc, sel, bo;
    bit got, tout;
    logic [31:0] exp_rd;

    // Model: walk the attempts in whole-cycle budgets
    lat = 1; sel_exp = 0; st = 0;
    for (int a = 0; a < p_n; a++) begin
      lat += p_gd[a] + 1;
      tout = (p_kind[a] == K_NONE) || (!p_sup && p_d[a] > T + 1);
      dur  = tout ? T + 1 : p_d[a];
      lat += dur + 1;
      sel_exp += dur + 1;
      if (tout) begin st = 2; break; end
      if (p_kind[a] == K_ACK) begin st = 0; break; end
      if (p_kind[a] == K_ERR || p_kind[a] == K_ERRX) begin st = 1; break; end
      if (a == MAXR) begin st = 3; break; end
      lat += 1;
    end
    exp_rd = (rnw && st == 0) ? rd_mem(addr) : 32'h0;

    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    att = 0; rc = 0; xc = 0; sel = 0; bo = 0; k = 0; got = 0;
    first_sel = -1; last_sel = -1;
    while (!got && k < lat + 40) begin
      @(negedge OPB_Clk);
      k++;
      // Command inputs wander after acceptance; the captured copy must not
      cmd_valid = $urandom_range(0, 1); cmd_rnw = $urandom_range(0, 1);
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = $urandom_range(0, 15);

      chk("req_and_sel", M_request & M_select, 1'b0);
      if (bo == 1) begin chk("backoff_idle", {M_select, M_request}, 2'b00); bo = 2; end
      else if (bo == 2) begin chk("rerequest", M_request, 1'b1); bo = 0; end

      if (M_select) begin
        chk("abus", M_ABus, addr);
        chk("be", M_BE, be);
        chk("rnw", M_RNW, rnw);
        chk("dbus", M_DBus, rnw ? 32'h0 : wdata);
        sel++;
        if (first_sel < 0) first_sel = k;
        last_sel = k;
      end else begin
        chk("orbus_zero", M_ABus | M_DBus | {27'h0, M_BE, M_RNW}, 32'h0);
      end

      if (rsp_valid) begin
        got = 1;
        cmd_valid = 1'b0;
        chk("latency", k, lat);
        chk("status", rsp_status, st);
        chk("rdata", rsp_rdata, exp_rd);
        chk("select_cycles", sel, sel_exp);
        chk("ready_in_resp", cmd_ready, 1'b0);
        last_rdata = rsp_rdata;
      end

      // Arbiter: grant in the planned REQ cycle, random noise elsewhere
      if (M_request) begin
        OPB_MGrant = (att < p_n) && (rc == p_gd[att]);
        rc++;
      end else begin
        OPB_MGrant = $urandom_range(0, 1);
      end
      // Slave
      OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0; OPB_DBus = $urandom;
      OPB_toutSup = M_select ? p_sup : 1'($urandom_range(0, 1));
      if (M_select && att < p_n) begin
        rc = 0;
        if (xc == p_d[att] && p_kind[att] != K_NONE) begin
          case (p_kind[att])
            K_ACK:  begin OPB_xferAck = 1; if (rnw) OPB_DBus = rd_mem(addr); end
            K_ERR:  OPB_errAck = 1;
            K_ERRX: begin OPB_errAck = 1; OPB_xferAck = 1; end
            default: begin OPB_retry = 1; if (att < MAXR) bo = 1; end
          endcase
          att++; xc = 0;
        end else begin
          xc++;
        end
      end
    end
    chk("rsp_seen", got, 1'b1);
    last_lat = k;
    cmd_valid = 1'b0;
    if (!rnw && st == 0) mem[addr] = merge(rd_mem(addr), wdata, be);
    @(negedge OPB_Clk);
    OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0; OPB_MGrant = 0;
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("ready_after_resp", cmd_ready, 1'b1);
  endtask

  initial begin
    int n, nrsp;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0100_0000; addrs[1] = 32'h0100_0004; addrs[2] = 32'h0100_0008;

    OPB_Rst = 1; cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_wdata = 0; cmd_be = 0;
    OPB_MGrant = 0; OPB_DBus = 0; OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0;
    OPB_toutSup = 0;

    // Reset state
    repeat (3) @(negedge OPB_Clk);
    chk("rst_ctrl", {M_request, M_select, M_RNW, M_busLock, M_seqAddr, rsp_valid,
                     rsp_status, cmd_ready}, 32'h0);
    chk("rst_bus", M_ABus | M_DBus | rsp_rdata | {28'h0, M_BE}, 32'h0);
    OPB_Rst = 0;
    @(negedge OPB_Clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Write then read back, single-cycle ack and immediate grant
    mk_plan(0, K_ACK, 0, 0); p_gd[0] = 0;
    run_cmd(0, 32'h0100_0000, 32'hDEAD_BEEF, 4'b1111);
    chk("wr_latency3", last_lat, 3);
    chk("wr_abus_one_cycle", last_sel - first_sel + 1, 1);
    mk_plan(0, K_ACK, 0, 0); p_gd[0] = 0;
    run_cmd(1, 32'h0100_0000, 32'h0, 4'b1111);
    chk("rd_latency3", last_lat, 3);
    chk("rd_back", last_rdata, 32'hDEAD_BEEF);

    // Grant delay 5, ack delay 3
    mk_plan(0, K_ACK, 0, 3); p_gd[0] = 5;
    run_cmd(1, 32'h0100_0000, 32'h0, 4'b1111);
    chk("delay_latency11", last_lat, 11);

    // errAck together with xferAck on a read
    mk_plan(0, K_ERRX, 0, 1);
    run_cmd(1, 32'h0100_0000, 32'h0, 4'b1111);

    // Two retries then ack; four retries exhaust
    mk_plan(2, K_ACK, 0, 1);
    run_cmd(0, 32'h0100_0004, 32'h1234_5678, 4'b0110);
    mk_plan(4, K_ACK, 0, 0);
    run_cmd(1, 32'h0100_0004, 32'h0, 4'b1111);

    // Timeout without suppress, then suppress for 40 cycles and ack
    mk_plan(0, K_NONE, 0, 0);
    run_cmd(1, 32'h0100_0008, 32'h0, 4'b1111);
    chk("tout_dist", last_lat - first_sel, T + 2);
    chk("tout_last_sel", last_lat - last_sel, 1);
    mk_plan(0, K_ACK, 1, 40);
    run_cmd(1, 32'h0100_0004, 32'h0, 4'b1111);

    // Random mix
    for (int i = 0; i < 14; i++) begin
      int fin;
      fin = $urandom_range(0, 5);
      mk_plan($urandom_range(0, 5), (fin > 2) ? K_ACK : fin, 1'($urandom_range(0, 1)),
              $urandom_range(0, 4));
      run_cmd(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 2)], $urandom,
              4'($urandom_range(0, 15)));
    end

    // Reset in the middle of XFER
    cmd_valid = 1; cmd_rnw = 1; cmd_addr = 32'h0100_0000; cmd_be = 4'hF;
    OPB_MGrant = 1; OPB_toutSup = 1;
    @(negedge OPB_Clk);
    cmd_valid = 0;
    n = 0;
    while (!M_select && n < 10) begin @(negedge OPB_Clk); n++; end
    chk("rst_xfer_entered", M_select, 1'b1);
    OPB_Rst = 1; OPB_MGrant = 0;
    @(negedge OPB_Clk);
    chk("rst_sel_drop", {M_select, M_request, rsp_valid}, 3'b000);
    chk("rst_ready_low", cmd_ready, 1'b0);
    @(negedge OPB_Clk);
    OPB_Rst = 0; OPB_toutSup = 0;
    @(negedge OPB_Clk);
    chk("rst_ready_high", cmd_ready, 1'b1);
    nrsp = 0;
    repeat (25) begin @(negedge OPB_Clk); if (rsp_valid) nrsp++; end
    chk("rst_no_rsp", nrsp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end
endmodule
